// File: rtl/spi_frame_buffer.sv
// SPI readout frame buffer: collects N_BYTES bytes plus header and ADC sample, presents them through a one-deep valid/ready slot.
// Optional idle-abort logic is guarded by SPI_FRAME_TIMEOUT_EN; when undefined, timeout is tied low.
module spi_frame_buffer #(
   parameter int  N_BYTES     = 5,
   parameter int  ADC_W       = 12,
   parameter int  TIMEOUT_CYC = 255,
   localparam int FRAME_W     = 24 + 8*N_BYTES + ADC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_start,
   input  logic [7:0]         spi_id_in,
   input  logic [7:0]         spi_select,
   input  logic [7:0]         spi_reg,
   input  logic               byte_vld,
   input  logic [7:0]         data_rec_in,
   input  logic [ADC_W-1:0]   xadc_rec_in,
   input  logic               frame_rdy,
   output logic               frame_vld,
   output logic [FRAME_W-1:0] frame_out,
   output logic               busy,
   output logic               overflow,
   output logic               timeout
);
   localparam int               CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int               BYTES_W = 8*N_BYTES;
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_BYTES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt, base_cnt;
   logic [BYTES_W-1:0] asm_q, asm_nxt, base_asm, filled, commit_bytes;
   logic [23:0]        hdr, hdr_nxt;
   logic               commit, slot_free, ovf_nxt, abort;

   assign busy = (state != IDLE);

   always_comb begin
      slot_free    = !frame_vld || frame_rdy;
      base_cnt     = frame_start ? '0 : cnt;
      base_asm     = frame_start ? '0 : asm_q;
      // A byte arriving with frame_start becomes byte0 of the new frame.
      filled       = base_asm;
      for (int k = 0; k < N_BYTES; k++) begin
         if (base_cnt == CNT_W'(k)) filled[8*(N_BYTES-1-k) +: 8] = data_rec_in;
      end
      state_nxt    = state;
      cnt_nxt      = cnt;
      asm_nxt      = asm_q;
      hdr_nxt      = hdr;
      commit_bytes = asm_q;
      commit       = 1'b0;
      ovf_nxt      = 1'b0;
      case (state)
         IDLE, COLLECT: begin
            if (frame_start) begin
               hdr_nxt   = {spi_id_in, spi_select, spi_reg};
               cnt_nxt   = '0;
               asm_nxt   = '0;
               state_nxt = COLLECT;
            end
            if (byte_vld && (frame_start || state == COLLECT)) begin
               if (base_cnt == LAST) begin
                  commit_bytes = filled;
                  if (slot_free) begin
                     commit    = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     asm_nxt   = filled;
                     state_nxt = FULL;
                  end
               end else begin
                  asm_nxt   = filled;
                  cnt_nxt   = base_cnt + CNT_W'(1);
                  state_nxt = COLLECT;
               end
            end else if (abort) begin
               state_nxt = IDLE;
            end
         end
         FULL: begin
            ovf_nxt = frame_start || byte_vld;
            if (frame_vld && frame_rdy) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         asm_q     <= '0;
         hdr       <= '0;
         frame_vld <= 1'b0;
         frame_out <= '0;
         overflow  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         asm_q    <= asm_nxt;
         hdr      <= hdr_nxt;
         overflow <= ovf_nxt;
         if (commit) begin
            frame_out <= {hdr_nxt, commit_bytes, xadc_rec_in};
            frame_vld <= 1'b1;
         end else if (frame_rdy) begin
            frame_vld <= 1'b0;
         end
      end
   end

`ifdef SPI_FRAME_TIMEOUT_EN
   localparam int          IDLE_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
   logic [IDLE_W-1:0] idle_cnt, idle_nxt;

   always_comb begin
      idle_nxt = '0;
      abort    = 1'b0;
      if (state == COLLECT && !frame_start && !byte_vld) begin
         if (idle_cnt == IDLE_LAST) abort = 1'b1;
         else                       idle_nxt = idle_cnt + IDLE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idle_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         idle_cnt <= idle_nxt;
         timeout  <= abort;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
   assign abort   = 1'b0;
   assign timeout = 1'b0;
`endif
endmodule

// File: doc/spi_frame_buffer.md
# spi_frame_buffer

Parametrised SPI readout frame buffer for the MOPS-Hub SPI/ADC readout path. Collects a configurable number of data bytes from the SPI receiver with an auto-incrementing byte counter, tags each frame with the SPI ID, select and register header and an ADC sample, and hands the completed frame to the downstream transmitter. A ready/valid handshake and a one-deep output slot (ping-pong with the assembly register) let the next frame be collected while the previous one waits.

## Interface
- N_BYTES, 5, data bytes per frame (1..16)
- ADC_W, 12, ADC sample width
- TIMEOUT_CYC, 255, max idle cycles between bytes (used only with SPI_FRAME_TIMEOUT_EN)
- FRAME_W, 24+8*N_BYTES+ADC_W (76 at defaults), derived, not overridable
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- frame_start  in  1  one-cycle pulse: start new frame, latch header
- spi_id_in  in  8  SPI ID header, latched on frame_start
- spi_select  in  8  select header, latched on frame_start
- spi_reg  in  8  register header, latched on frame_start
- byte_vld  in  1  data_rec_in valid strobe
- data_rec_in  in  8  data byte from SPI receiver
- xadc_rec_in  in  ADC_W  ADC sample, captured at frame commit
- frame_rdy  in  1  downstream accepts frame
- frame_vld  out  1  frame_out holds a complete frame
- frame_out  out  FRAME_W  {spi_id, spi_select, spi_reg, byte0..byte(N-1), adc}; byte0 = first received, most significant
- busy  out  1  state is not IDLE
- overflow  out  1  one-cycle pulse: input dropped
- timeout  out  1  one-cycle pulse: partial frame aborted (0 when macro absent)

## Operation
- States: IDLE, COLLECT, FULL.
- IDLE: frame_start -> latch header, clear counter and assembly register, go COLLECT. byte_vld without frame_start ignored (no overflow).
- COLLECT: each byte_vld writes data_rec_in to slot cnt, cnt++. On byte N_BYTES: commit if output slot free (!frame_vld or frame_rdy this cycle) -> go IDLE; else go FULL.
- Commit: frame_out <= {header, bytes, xadc_rec_in sampled that cycle}; frame_vld <= 1.
- FULL: commit when slot frees (frame_vld & frame_rdy), then IDLE. byte_vld or frame_start in FULL dropped, overflow pulses.
- frame_start during COLLECT: partial frame discarded, header relatched, cnt restarts. frame_start & byte_vld same cycle (IDLE or COLLECT): byte is byte0 of the new frame.
- frame_vld clears on frame_vld & frame_rdy unless a commit occurs the same cycle (then stays 1 with new data).
- frame_out stable while frame_vld & !frame_rdy.

## Timing
- Reset (rst=0 at clk edge): state IDLE, cnt 0, frame_vld 0, frame_out 0, busy 0, overflow 0, timeout 0; reset overrides all inputs same edge, incl. mid-frame and in FULL (held frame lost).
- Last byte at edge t, slot free -> frame_vld=1 after edge t (latency 1 cycle).
- Back-to-back: frame_start may coincide with the edge after commit; throughput up to one byte/cycle.
- overflow, timeout: registered, high exactly one cycle after causing edge.

## Configuration
- SPI_FRAME_TIMEOUT_EN defined: idle counter in COLLECT, cleared on byte_vld/frame_start; reaching TIMEOUT_CYC cycles without a byte aborts the frame -> IDLE, timeout pulse, no commit.
- Not defined: no counter, COLLECT waits indefinitely, timeout tied 0.

## Test plan
- Defaults: frame_start with id 0x12/sel 0x01/reg 0x34, bytes 0xA1..0xA5 consecutive, xadc 0xABC, frame_rdy=1 -> frame_vld one cycle after 0xA5, frame_out = 0x12_01_34_A1A2A3A4A5_ABC, then frame_vld 0.
- frame_rdy=0: two full frames -> second in FULL, busy=1; extra byte -> overflow pulse; frame_rdy=1 -> frame 1 accepted, frame 2 presented next cycle, no corruption.
- frame_start after 3 bytes, then 5 new bytes -> only new frame output, new header.
- rst=0 at byte 3 -> all outputs 0; next full frame correct.
- With SPI_FRAME_TIMEOUT_EN, TIMEOUT_CYC=8: 2 bytes then 8 idle cycles -> timeout pulse, IDLE, no frame_vld; 7 idle cycles -> frame completes normally.
- N_BYTES=1, ADC_W=10: frame_start+byte_vld same cycle -> frame_vld next cycle, FRAME_W=42.
